// File: rtl/cam_histogram_engine.sv
// Camera histogram engine: bins pixels of one armed frame, then
// streams the per-bin counts out over a valid/ready readout port.
module cam_histogram_engine #(
  parameter int PIX_W    = 10,
  parameter int BIN_BITS = 8,
  parameter int CNT_W    = 24
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic [PIX_W-1:0]          pix_data_i,
  input  logic                      fv_i,
  input  logic                      lv_i,
  input  logic                      enable_i,
  input  logic                      rd_ready_i,
  output logic                      rd_valid_o,
  output logic [BIN_BITS-1:0]       rd_bin_o,
  output logic [CNT_W-1:0]          rd_count_o,
  output logic                      rd_last_o,
  output logic [CNT_W+BIN_BITS-1:0] frame_pixels_o,
  output logic                      sat_o,
  output logic                      frame_drop_o,
  output logic                      busy_o
);

  localparam int NBINS = 1 << BIN_BITS;
  localparam int FP_W  = CNT_W + BIN_BITS;

  localparam logic [2:0] S_CLEAR = 3'd0;
  localparam logic [2:0] S_WAIT  = 3'd1;
  localparam logic [2:0] S_ACCUM = 3'd2;
  localparam logic [2:0] S_FLUSH = 3'd3;
  localparam logic [2:0] S_DRAIN = 3'd4;

  localparam logic [CNT_W-1:0]    CNT_MAX = '1;
  localparam logic [CNT_W-1:0]    CNT_ONE = 1;
  localparam logic [FP_W-1:0]     FP_MAX  = '1;
  localparam logic [FP_W-1:0]     FP_ONE  = 1;
  localparam logic [BIN_BITS-1:0] BIN_END = '1;
  localparam logic [BIN_BITS-1:0] BIN_ONE = 1;

  logic [2:0]          state_q;
  logic [BIN_BITS-1:0] idx_q;
  logic                flush_q;
  logic                fv_q;
  logic                drop_q;
  logic [FP_W-1:0]     fpix_q;
  logic                sat_q;

  logic [CNT_W-1:0]    bins_q [NBINS];

  logic                s1_valid_q;
  logic [BIN_BITS-1:0] s1_bin_q;
  logic                w_valid_q;
  logic [BIN_BITS-1:0] w_bin_q;
  logic [CNT_W-1:0]    w_data_q;

  logic                fv_rise;
  logic                start;
  logic                pix_ok;
  logic [BIN_BITS-1:0] bin_in;
  logic [CNT_W-1:0]    cur_cnt;
  logic                sat_hit;
  logic [CNT_W-1:0]    nxt_cnt;
  logic                unused_pix;

  assign fv_rise = fv_i & ~fv_q;
  assign start   = (state_q == S_WAIT) & fv_rise & enable_i;
  assign bin_in  = pix_data_i[PIX_W-1 -: BIN_BITS];
  assign pix_ok  = fv_i & lv_i
                 & ((state_q == S_ACCUM) | start);

  assign unused_pix = ^pix_data_i;

  // Forward the in-flight write so back-to-back hits never lose a count.
  always_comb begin
    cur_cnt = bins_q[s1_bin_q];
    if (w_valid_q && (w_bin_q == s1_bin_q)) begin
      cur_cnt = w_data_q;
    end
    sat_hit = (cur_cnt == CNT_MAX);
    nxt_cnt = sat_hit ? cur_cnt : cur_cnt + CNT_ONE;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      s1_valid_q <= 1'b0;
      s1_bin_q   <= '0;
      w_valid_q  <= 1'b0;
      w_bin_q    <= '0;
      w_data_q   <= '0;
    end else begin
      s1_valid_q <= pix_ok;
      s1_bin_q   <= bin_in;
      w_valid_q  <= s1_valid_q;
      w_bin_q    <= s1_bin_q;
      w_data_q   <= nxt_cnt;
    end
  end

  always_ff @(posedge clk_i) begin
    if (state_q == S_CLEAR) begin
      bins_q[idx_q] <= '0;
    end else if (w_valid_q) begin
      bins_q[w_bin_q] <= w_data_q;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= S_CLEAR;
      idx_q   <= '0;
      flush_q <= 1'b0;
    end else begin
      unique case (state_q)
        S_CLEAR: begin
          idx_q <= idx_q + BIN_ONE;
          if (idx_q == BIN_END) begin
            state_q <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (start) begin
            state_q <= S_ACCUM;
          end
        end
        S_ACCUM: begin
          if (!fv_i) begin
            state_q <= S_FLUSH;
            flush_q <= 1'b0;
          end
        end
        S_FLUSH: begin
          flush_q <= 1'b1;
          if (flush_q) begin
            state_q <= S_DRAIN;
            idx_q   <= '0;
          end
        end
        S_DRAIN: begin
          if (rd_ready_i) begin
            idx_q <= idx_q + BIN_ONE;
            if (idx_q == BIN_END) begin
              state_q <= S_CLEAR;
            end
          end
        end
        default: begin
          state_q <= S_CLEAR;
          idx_q   <= '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      fv_q   <= 1'b0;
      drop_q <= 1'b0;
      fpix_q <= '0;
      sat_q  <= 1'b0;
    end else begin
      fv_q   <= fv_i;
      drop_q <= fv_rise & ((state_q != S_WAIT) | ~enable_i);
      if (state_q == S_CLEAR) begin
        fpix_q <= '0;
        sat_q  <= 1'b0;
      end else begin
        if (pix_ok && (fpix_q != FP_MAX)) begin
          fpix_q <= fpix_q + FP_ONE;
        end
        if (s1_valid_q && sat_hit) begin
          sat_q <= 1'b1;
        end
      end
    end
  end

  assign rd_valid_o     = (state_q == S_DRAIN);
  assign rd_last_o      = rd_valid_o & (idx_q == BIN_END);
  assign rd_bin_o       = rd_valid_o ? idx_q : '0;
  assign rd_count_o     = rd_valid_o ? bins_q[idx_q] : '0;
  assign frame_pixels_o = fpix_q;
  assign sat_o          = sat_q;
  assign frame_drop_o   = drop_q;
  assign busy_o         = (state_q != S_WAIT);

endmodule

// File: tb/tb_cam_histogram_engine.sv
// Directed bench for cam_histogram_engine, PIX_W=10 BIN_BITS=4 CNT_W=8.
module tb_cam_histogram_engine;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [9:0]  pix = '0;
  logic        fv = 1'b0;
  logic        lv = 1'b0;
  logic        enable = 1'b0;
  logic        rd_ready = 1'b0;
  logic        rd_valid;
  logic [3:0]  rd_bin;
  logic [7:0]  rd_count;
  logic        rd_last;
  logic [11:0] frame_pixels;
  logic        sat;
  logic        frame_drop;
  logic        busy;

  int checks = 0;
  int failures = 0;

  logic [7:0]  got_cnt [16];
  int          got_n;
  bit          order_ok;
  bit          stable_ok;
  bit          last_ok;
  bit          term_ok;
  logic [11:0] fp_seen;
  logic        sat_seen;

  always #5 clk = ~clk;

  cam_histogram_engine #(
    .PIX_W(10),
    .BIN_BITS(4),
    .CNT_W(8)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .pix_data_i(pix),
    .fv_i(fv),
    .lv_i(lv),
    .enable_i(enable),
    .rd_ready_i(rd_ready),
    .rd_valid_o(rd_valid),
    .rd_bin_o(rd_bin),
    .rd_count_o(rd_count),
    .rd_last_o(rd_last),
    .frame_pixels_o(frame_pixels),
    .sat_o(sat),
    .frame_drop_o(frame_drop),
    .busy_o(busy)
  );

  task automatic wait_idle(output bit ok, output bit saw_valid);
    ok = 1'b0;
    saw_valid = 1'b0;
    for (int c = 0; c < 300 && !ok; c++) begin
      @(negedge clk);
      if (rd_valid === 1'b1) saw_valid = 1'b1;
      if (busy === 1'b0) ok = 1'b1;
    end
  endtask

  task automatic frame_begin();
    @(negedge clk);
    enable = 1'b1;
    fv = 1'b1;
    lv = 1'b0;
  endtask

  task automatic px(input logic [9:0] v);
    @(negedge clk);
    lv = 1'b1;
    pix = v;
  endtask

  task automatic gap(input int n);
    repeat (n) begin
      @(negedge clk);
      lv = 1'b0;
    end
  endtask

  task automatic frame_end();
    @(negedge clk);
    lv = 1'b0;
    fv = 1'b0;
  endtask

  // mode 0: ready always high; mode 1: ready follows 1,0,0,1
  task automatic drain(input int mode);
    bit done;
    bit have_hold;
    bit r;
    int step;
    logic [3:0] hb;
    logic [7:0] hc;
    logic       hl;
    logic [3:0] pat;
    pat = 4'b1001;
    for (int i = 0; i < 16; i++) got_cnt[i] = 8'hEE;
    got_n = 0;
    order_ok = 1'b1;
    stable_ok = 1'b1;
    last_ok = 1'b1;
    term_ok = 1'b0;
    done = 1'b0;
    have_hold = 1'b0;
    step = 0;
    hb = '0;
    hc = '0;
    hl = 1'b0;
    for (int c = 0; c < 600 && !done; c++) begin
      @(negedge clk);
      if (rd_valid === 1'b1) begin
        if (got_n == 0 && !have_hold) begin
          fp_seen = frame_pixels;
          sat_seen = sat;
        end
        if (have_hold && (rd_bin !== hb || rd_count !== hc
                          || rd_last !== hl))
          stable_ok = 1'b0;
        r = (mode == 0) ? 1'b1 : pat[3 - (step % 4)];
        step++;
        rd_ready = r;
        if (r) begin
          if (rd_bin !== 4'(got_n)) order_ok = 1'b0;
          if (rd_last !== (got_n == 15)) last_ok = 1'b0;
          if (!$isunknown(rd_bin)) got_cnt[rd_bin] = rd_count;
          got_n++;
          have_hold = 1'b0;
          if (rd_last === 1'b1 || got_n > 16) done = 1'b1;
        end else begin
          have_hold = 1'b1;
          hb = rd_bin;
          hc = rd_count;
          hl = rd_last;
        end
      end else begin
        rd_ready = (mode == 0);
      end
    end
    @(negedge clk);
    term_ok = (rd_valid === 1'b0) && (rd_last === 1'b0);
    rd_ready = 1'b0;
  endtask

  task automatic test_reset();
    int n;
    bit bad;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({rd_valid, rd_last, rd_bin, rd_count, frame_pixels, sat,
         frame_drop, busy} !== {1'b0, 1'b0, 4'h0, 8'h00, 12'h000,
         1'b0, 1'b0, 1'b1}) begin
      failures++;
      $display("FAIL reset_outputs: valid=%b last=%b bin=%h cnt=%h fp=%h sat=%b drop=%b busy=%b, want all 0 busy=1",
               rd_valid, rd_last, rd_bin, rd_count, frame_pixels, sat,
               frame_drop, busy);
    end
    rst = 1'b0;
    n = 0;
    bad = 1'b0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      n++;
      if ({rd_valid, rd_last, rd_bin, rd_count, frame_pixels, sat,
           frame_drop} !== '0) bad = 1'b1;
      if (busy !== 1'b1) break;
    end
    checks++;
    if (n != 16) begin
      failures++;
      $display("FAIL clear_busy_cycles: got %0d, want 16", n);
    end
    checks++;
    if (bad) begin
      failures++;
      $display("FAIL clear_outputs_zero: got nonzero output, want 0");
    end
  endtask

  task automatic test_basic_frame();
    bit ok;
    bit sv;
    int nz;
    wait_idle(ok, sv);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL basic_idle: got busy=%b, want 0", busy);
    end
    frame_begin();
    for (int l = 0; l < 2; l++) begin
      px(10'h000);
      px(10'h03F);
      px(10'h040);
      px(10'h3FF);
      gap(2);
    end
    frame_end();
    drain(0);
    checks++;
    if (got_n != 16 || !order_ok || !last_ok || !term_ok) begin
      failures++;
      $display("FAIL basic_stream: got words=%0d order=%b last=%b term=%b, want 16 1 1 1",
               got_n, order_ok, last_ok, term_ok);
    end
    checks++;
    if (got_cnt[0] !== 8'd4) begin
      failures++;
      $display("FAIL basic_bin0: got %0d, want 4", got_cnt[0]);
    end
    checks++;
    if (got_cnt[1] !== 8'd2) begin
      failures++;
      $display("FAIL basic_bin1: got %0d, want 2", got_cnt[1]);
    end
    checks++;
    if (got_cnt[15] !== 8'd2) begin
      failures++;
      $display("FAIL basic_bin15: got %0d, want 2", got_cnt[15]);
    end
    nz = 0;
    for (int i = 2; i < 15; i++) if (got_cnt[i] !== 8'd0) nz++;
    checks++;
    if (nz != 0) begin
      failures++;
      $display("FAIL basic_other_bins: got %0d nonzero, want 0", nz);
    end
    checks++;
    if (fp_seen !== 12'd8 || sat_seen !== 1'b0) begin
      failures++;
      $display("FAIL basic_fp_sat: got fp=%0d sat=%b, want 8 0",
               fp_seen, sat_seen);
    end
  endtask

  task automatic test_saturation();
    bit ok;
    bit sv;
    int nz;
    wait_idle(ok, sv);
    frame_begin();
    for (int i = 0; i < 300; i++) px(10'h155);
    frame_end();
    drain(0);
    checks++;
    if (got_n != 16 || got_cnt[5] !== 8'd255) begin
      failures++;
      $display("FAIL sat_bin5: got words=%0d bin5=%0d, want 16 255",
               got_n, got_cnt[5]);
    end
    checks++;
    if (sat_seen !== 1'b1 || fp_seen !== 12'd300) begin
      failures++;
      $display("FAIL sat_flags: got sat=%b fp=%0d, want 1 300",
               sat_seen, fp_seen);
    end
    nz = 0;
    for (int i = 0; i < 16; i++)
      if (i != 5 && got_cnt[i] !== 8'd0) nz++;
    checks++;
    if (nz != 0) begin
      failures++;
      $display("FAIL sat_other_bins: got %0d nonzero, want 0", nz);
    end
  endtask

  task automatic test_backpressure();
    bit ok;
    bit sv;
    wait_idle(ok, sv);
    frame_begin();
    px(10'h1C0);
    px(10'h3FF);
    px(10'h1C0);
    px(10'h1C0);
    px(10'h000);
    px(10'h3FF);
    px(10'h000);
    frame_end();
    drain(1);
    checks++;
    if (got_n != 16 || !order_ok || !last_ok || !term_ok) begin
      failures++;
      $display("FAIL bp_stream: got words=%0d order=%b last=%b term=%b, want 16 1 1 1",
               got_n, order_ok, last_ok, term_ok);
    end
    checks++;
    if (!stable_ok) begin
      failures++;
      $display("FAIL bp_stable: got word changed while stalled, want stable");
    end
    checks++;
    if (got_cnt[7] !== 8'd3 || got_cnt[15] !== 8'd2
        || got_cnt[0] !== 8'd2) begin
      failures++;
      $display("FAIL bp_counts: got b7=%0d b15=%0d b0=%0d, want 3 2 2",
               got_cnt[7], got_cnt[15], got_cnt[0]);
    end
  endtask

  task automatic test_drop_in_drain();
    bit ok;
    bit sv;
    bit seen;
    wait_idle(ok, sv);
    frame_begin();
    px(10'h080);
    px(10'h080);
    px(10'h080);
    frame_end();
    rd_ready = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 50 && !seen; c++) begin
      @(negedge clk);
      if (rd_valid === 1'b1) seen = 1'b1;
    end
    checks++;
    if (!seen) begin
      failures++;
      $display("FAIL drop_drain_entry: got no rd_valid, want 1");
    end
    fv = 1'b1;
    lv = 1'b1;
    pix = 10'h0C0;
    @(negedge clk);
    checks++;
    if (frame_drop !== 1'b1) begin
      failures++;
      $display("FAIL drop_pulse_high: got %b, want 1", frame_drop);
    end
    lv = 1'b0;
    @(negedge clk);
    checks++;
    if (frame_drop !== 1'b0) begin
      failures++;
      $display("FAIL drop_pulse_width: got %b, want 0", frame_drop);
    end
    fv = 1'b0;
    drain(0);
    checks++;
    if (got_cnt[2] !== 8'd3 || got_cnt[3] !== 8'd0) begin
      failures++;
      $display("FAIL drop_first_hist: got b2=%0d b3=%0d, want 3 0",
               got_cnt[2], got_cnt[3]);
    end
    wait_idle(ok, sv);
    frame_begin();
    px(10'h0C0);
    px(10'h0C0);
    frame_end();
    drain(0);
    checks++;
    if (got_cnt[3] !== 8'd2 || got_cnt[2] !== 8'd0
        || fp_seen !== 12'd2) begin
      failures++;
      $display("FAIL drop_next_hist: got b3=%0d b2=%0d fp=%0d, want 2 0 2",
               got_cnt[3], got_cnt[2], fp_seen);
    end
  endtask

  task automatic test_reset_mid_accum();
    bit ok;
    bit sv;
    wait_idle(ok, sv);
    frame_begin();
    for (int i = 0; i < 5; i++) px(10'h200);
    @(negedge clk);
    lv = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({rd_valid, rd_last, rd_bin, rd_count, frame_pixels, sat,
         frame_drop, busy} !== {28'h0, 1'b1}) begin
      failures++;
      $display("FAIL rst_mid_outputs: valid=%b fp=%0d sat=%b drop=%b busy=%b, want 0 0 0 0 1",
               rd_valid, frame_pixels, sat, frame_drop, busy);
    end
    rst = 1'b0;
    fv = 1'b0;
    wait_idle(ok, sv);
    checks++;
    if (!ok || sv) begin
      failures++;
      $display("FAIL rst_mid_clear: got idle=%b saw_valid=%b, want 1 0",
               ok, sv);
    end
    frame_begin();
    px(10'h000);
    px(10'h000);
    px(10'h000);
    frame_end();
    drain(0);
    checks++;
    if (got_cnt[0] !== 8'd3 || got_cnt[8] !== 8'd0
        || fp_seen !== 12'd3) begin
      failures++;
      $display("FAIL rst_mid_hist: got b0=%0d b8=%0d fp=%0d, want 3 0 3",
               got_cnt[0], got_cnt[8], fp_seen);
    end
  endtask

  initial begin
    test_reset();
    test_basic_frame();
    test_saturation();
    test_backpressure();
    test_drop_in_drain();
    test_reset_mid_accum();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
